fpga_config_readback: RTL and testbench

Configuration readback engine for the `fpga` fabric. It is the read side of the frame-wise configuration load, which writes 224-bit frames selected by a one-hot `configs_en`. This block walks the same 43 frames in load order using a one-hot read select and captures each 224-bit frame. It then serializes the frame LSB-first over a valid/ready word stream, so a host or bench can compare the result against the `.bs` bitstream file.

---
 rtl/fpga_config_readback.sv | 189 ++++++++++++++++++
 tb/tb_fpga_config_readback.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_config_readback.sv
// fpga_config_readback: walks the configuration frames in load order with a
// one-hot read select. It captures each frame and streams it LSB-first as
// OUT_W-bit words over a valid/ready interface.
//
// Ports:
//   clock, rst_n   - rising-edge clock, asynchronous active-low reset
//   start          - one-cycle readback request, sampled only in IDLE
//   abort          - terminates an in-progress readback
//   busy           - high from the cycle after start until DONE is left
//   done           - one-cycle end-of-readback pulse
//   aborted        - qualifies done when the readback was aborted
//   cfg_rd_en      - one-hot frame read select, one cycle per frame
//   cfg_rd_data    - frame data, valid the cycle after cfg_rd_en
//   out_data/out_valid/out_ready - word stream
//
// Optional feature: define READBACK_CHECKSUM_EN to append one XOR checksum
// word, covering all data words, after the last frame.
module fpga_config_readback #(
  parameter int unsigned FRAME_W    = 224,
  parameter int unsigned NUM_FRAMES = 43,
  parameter int unsigned OUT_W      = 8
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [NUM_FRAMES-1:0] cfg_rd_en,
  input  logic [FRAME_W-1:0]    cfg_rd_data,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned WORDS  = FRAME_W / OUT_W;
  localparam int unsigned WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned IDX_W  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  localparam logic [WCNT_W-1:0]     LAST_WORD  = WCNT_W'(WORDS - 1);
  localparam logic [IDX_W-1:0]      LAST_FRAME = IDX_W'(NUM_FRAMES - 1);
  localparam logic [NUM_FRAMES-1:0] SEL_ONE    = NUM_FRAMES'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_SHIFT,
`ifdef READBACK_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic [FRAME_W-1:0]      shreg_q, shreg_d;
`ifdef READBACK_CHECKSUM_EN
  logic [OUT_W-1:0]        csum_q, csum_d;
`endif
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic [NUM_FRAMES-1:0]   cfg_rd_en_q, cfg_rd_en_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    xfer;

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign cfg_rd_en = cfg_rd_en_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // Next state plus next values of every registered output.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    shreg_d   = shreg_q;
`ifdef READBACK_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    aborted_d = 1'b0;
    xfer      = out_valid_q && out_ready;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          idx_d   = '0;
`ifdef READBACK_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_REQ: state_d = S_CAP;
      S_CAP: begin
        shreg_d = cfg_rd_data;
        wcnt_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (xfer) begin
          shreg_d = shreg_q >> OUT_W;
          wcnt_d  = wcnt_q + WCNT_W'(1);
`ifdef READBACK_CHECKSUM_EN
          csum_d  = csum_q ^ out_data_q;
`endif
          if (wcnt_q == LAST_WORD) begin
            if (idx_q < LAST_FRAME) begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_REQ;
            end else begin
`ifdef READBACK_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef READBACK_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = S_DONE;
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything while a readback is in flight; a word that
    // transfers in the same cycle has already been accepted by the sink.
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d   = S_DONE;
      aborted_d = 1'b1;
    end

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    cfg_rd_en_d = (state_d == S_REQ) ? (SEL_ONE << idx_d) : '0;
    out_valid_d = (state_d == S_SHIFT);
    out_data_d  = (state_d == S_SHIFT) ? shreg_d[OUT_W-1:0] : '0;
`ifdef READBACK_CHECKSUM_EN
    if (state_d == S_CSUM) begin
      out_valid_d = 1'b1;
      out_data_d  = csum_d;
    end
`endif
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wcnt_q      <= '0;
      shreg_q     <= '0;
`ifdef READBACK_CHECKSUM_EN
      csum_q      <= '0;
`endif
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cfg_rd_en_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      shreg_q     <= shreg_d;
`ifdef READBACK_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cfg_rd_en_q <= cfg_rd_en_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fpga_config_readback.sv
// Testbench for fpga_config_readback: fabric model, randomized backpressure,
// and a word-stream reference built directly from the frame contents.
module tb_fpga_config_readback;

  localparam int unsigned FRAME_W    = 224;
  localparam int unsigned NUM_FRAMES = 43;
  localparam int unsigned OUT_W      = 8;
  localparam int unsigned WORDS      = FRAME_W / OUT_W;
  localparam int unsigned PER_FRAME  = WORDS + 2;
  localparam int          BUDGET     = 4 * NUM_FRAMES * PER_FRAME + 200;
`ifdef READBACK_CHECKSUM_EN
  localparam int          CS = 1;
`else
  localparam int          CS = 0;
`endif

  logic                  clock = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic [NUM_FRAMES-1:0] cfg_rd_en;
  logic [FRAME_W-1:0]    cfg_rd_data;
  logic [OUT_W-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready = 1'b1;

  fpga_config_readback #(
    .FRAME_W(FRAME_W), .NUM_FRAMES(NUM_FRAMES), .OUT_W(OUT_W)
  ) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .cfg_rd_en(cfg_rd_en), .cfg_rd_data(cfg_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Fabric: one-cycle read latency.
  logic [FRAME_W-1:0] frames [NUM_FRAMES];
  always @(posedge clock)
    for (int k = 0; k < NUM_FRAMES; k++)
      if (cfg_rd_en[k]) cfg_rd_data <= frames[k];

  // Sink readiness: 0 = always ready, 1 = toggle, 2 = random.
  int rmode = 0;
  always @(posedge clock) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference stream: every frame's words LSB-first, optionally the XOR word.
  logic [OUT_W-1:0] expq [$];
  function automatic void build_exp();
    logic [OUT_W-1:0] x;
    logic [OUT_W-1:0] w;
    x = '0;
    expq.delete();
    for (int k = 0; k < NUM_FRAMES; k++)
      for (int j = 0; j < WORDS; j++) begin
        w = frames[k][OUT_W*j +: OUT_W];
        expq.push_back(w);
        x ^= w;
      end
`ifdef READBACK_CHECKSUM_EN
    expq.push_back(x);
`endif
  endfunction

  function automatic void fill_bytes();
    for (int k = 0; k < NUM_FRAMES; k++) frames[k] = {WORDS{OUT_W'(k)}};
  endfunction

  function automatic void fill_random();
    for (int k = 0; k < NUM_FRAMES; k++)
      for (int j = 0; j < WORDS; j++) frames[k][OUT_W*j +: OUT_W] = OUT_W'($urandom);
  endfunction

  // Per-run observation state, shared between the run task and the monitor.
  bit                    active = 1'b0;
  bit                    done_seen;
  bit                    aborted_seen;
  bit                    prev_stall;
  logic [OUT_W-1:0]      prev_data;
  int                    s0;
  int                    rel;
  int                    stalls;
  int                    req_cnt;
  int                    done_rel;
  logic [OUT_W-1:0]      got [$];
  int                    req_rel [$];
  logic [NUM_FRAMES-1:0] exp_en;

  // Monitor: every cycle of an active readback, compare against the model.
  always @(negedge clock) begin
    if (active && !done_seen) begin
      rel = cyc - s0 + 1;
      check("busy", 64'(busy), 64'(1));
      if (out_valid) begin
        if (got.size() < expq.size())
          check("word", 64'(out_data), 64'(expq[got.size()]));
        else
          check("extra_word", 64'(got.size()), 64'(expq.size() - 1));
        if (prev_stall) check("stall_hold", 64'(out_data), 64'(prev_data));
        if (out_ready) got.push_back(out_data);
        else           stalls++;
      end else if (prev_stall && !done) begin
        check("stall_valid", 64'(out_valid), 64'(1));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (cfg_rd_en != '0) begin
        req_rel.push_back(rel);
        if (req_cnt < NUM_FRAMES) begin
          exp_en = '0;
          exp_en[req_cnt] = 1'b1;
          check("rd_en", 64'(cfg_rd_en), 64'(exp_en));
          check("rd_en_cyc", 64'(rel), 64'(1 + PER_FRAME * req_cnt + stalls));
        end else begin
          check("rd_en_extra", 64'(req_cnt), 64'(NUM_FRAMES - 1));
        end
        req_cnt++;
      end
      if (done) begin
        done_seen    = 1'b1;
        done_rel     = rel;
        aborted_seen = aborted;
        check("valid_in_done", 64'(out_valid), 64'(0));
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"},  64'(busy),      64'(0));
    check({name, "_done"},  64'(done),      64'(0));
    check({name, "_abt"},   64'(aborted),   64'(0));
    check({name, "_rden"},  64'(cfg_rd_en), 64'(0));
    check({name, "_valid"}, 64'(out_valid), 64'(0));
    check({name, "_data"},  64'(out_data),  64'(0));
  endtask

  // One readback. abort_cyc/stray_cyc/reset_cyc of 0 mean "not used".
  task automatic run(input int abort_cyc, input bit abort_with_start,
                     input int stray_cyc, input int reset_cyc);
    int  nexp;
    bit  was_reset;
    was_reset = 1'b0;
    build_exp();
    got.delete();
    req_rel.delete();
    stalls = 0; req_cnt = 0; done_rel = 0;
    done_seen = 1'b0; aborted_seen = 1'b0; prev_stall = 1'b0;
    @(posedge clock); #1 start = 1'b1; abort = abort_with_start;
    @(posedge clock); #1 start = 1'b0; abort = 1'b0;
    s0 = cyc;
    active = 1'b1;
    for (int i = 1; i < BUDGET && !done_seen; i++) begin
      if (i == reset_cyc) begin
        active = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_rst");
        check("rst_no_done", 64'(done_seen), 64'(0));
        was_reset = 1'b1;
        break;
      end
      if (i == abort_cyc) abort = 1'b1;
      if (i == stray_cyc) start = 1'b1;
      @(posedge clock); #1 abort = 1'b0; start = 1'b0;
    end
    active = 1'b0;
    if (was_reset) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        check("rst_hold_done", 64'(done), 64'(0));
        check("rst_hold_busy", 64'(busy), 64'(0));
      end
      rst_n = 1'b1;
    end else begin
      check("done_timeout", 64'(done_seen), 64'(1));
      @(negedge clock);
      check_idle_outputs("after_done");
      if (abort_cyc > 0) begin
        nexp = 0;
        for (int c = 3; c <= abort_cyc; c++)
          if (((c - 1) % PER_FRAME) >= 2) nexp++;
        check("abort_done_cyc", 64'(done_rel), 64'(abort_cyc + 1));
        check("abort_flag", 64'(aborted_seen), 64'(1));
        check("abort_words", 64'(got.size()), 64'(nexp));
      end else begin
        check("done_cyc", 64'(done_rel),
              64'(1 + NUM_FRAMES * PER_FRAME + CS + stalls));
        check("aborted_low", 64'(aborted_seen), 64'(0));
        check("word_count", 64'(got.size()), 64'(expq.size()));
        check("req_count", 64'(req_cnt), 64'(NUM_FRAMES));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    fill_bytes();
    repeat (3) @(posedge clock);
    #1 check_idle_outputs("reset");
    @(negedge clock) rst_n = 1'b1;

    // Basic: frame k is all byte k, sink always ready.
    rmode = 0;
    fill_bytes();
    run(0, 1'b0, 0, 0);
    check("basic_n",    64'(got.size()), 64'(1204 + CS));
    check("basic_done", 64'(done_rel),   64'(1291 + CS));
    check("basic_w0",   64'(got[0]),     64'(8'h00));
    check("basic_w28",  64'(got[28]),    64'(8'h01));
    check("basic_last", 64'(got[1203]),  64'(8'h2A));
    check("basic_req1", 64'(req_rel[1]), 64'(31));
    check("basic_req2", 64'(req_rel[2]), 64'(61));
`ifdef READBACK_CHECKSUM_EN
    check("basic_csum", 64'(got[1204]),  64'(8'h00));
`endif

    // LSB-first ordering: frame 0 byte j is j+1.
    for (int j = 0; j < WORDS; j++) frames[0][OUT_W*j +: OUT_W] = OUT_W'(j + 1);
    run(0, 1'b0, 0, 0);
    check("lsb_w0",  64'(got[0]),  64'(8'h01));
    check("lsb_w1",  64'(got[1]),  64'(8'h02));
    check("lsb_w27", 64'(got[27]), 64'(8'h1C));

    // Toggling backpressure plus an ignored start in mid-readback.
    rmode = 1;
    fill_bytes();
    run(0, 1'b0, 50, 0);

    // Random frame data with random backpressure.
    rmode = 2;
    for (int r = 0; r < 2; r++) begin
      fill_random();
      run(0, 1'b0, $urandom_range(5, 1200), 0);
    end

    // Abort at cycle 100, then a restart with start and abort together.
    rmode = 0;
    fill_bytes();
    for (int j = 0; j < WORDS; j++) frames[0][OUT_W*j +: OUT_W] = OUT_W'(j + 1);
    run(100, 1'b0, 0, 0);
    check("abort_n92",  64'(got.size()), 64'(92));
    check("abort_d101", 64'(done_rel),   64'(101));
    run(0, 1'b1, 0, 0);
    check("restart_w0", 64'(got[0]), 64'(8'h01));

    // Reset mid-readback, then a full readback from frame 0.
    run(0, 1'b0, 0, 500);
    run(0, 1'b0, 0, 0);
    check("post_rst_w0", 64'(got[0]), 64'(8'h01));

`ifdef READBACK_CHECKSUM_EN
    fill_bytes();
    frames[5][OUT_W-1:0] = 8'hFF;
    run(0, 1'b0, 0, 0);
    check("csum_fa",   64'(got[1204]), 64'(8'hFA));
    check("csum_done", 64'(done_rel),  64'(1292));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
